// File: rtl/uart_tx_buffered.sv
// FIFO-fed UART transmitter: LSB-first payload framed by a start bit and STOP_BITS stop bits, frames back-to-back with no idle gap.
// Define UART_TX_PARITY_EN to insert an odd-parity bit between the payload and the stop bits.
module uart_tx_buffered #(
    parameter int WIDTH        = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_enable,
    input  logic [WIDTH-1:0]              tx_data,
    input  logic                          ld_tx_data,
    output logic                          ld_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx_overflow
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(WIDTH + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [WIDTH-1:0]  shift;
    logic [CW-1:0]     bit_cnt;
    logic [7:0]        baud;
`ifdef UART_TX_PARITY_EN
    logic              par_bit;
`endif

    logic push;
    logic pop;
    logic baud_end;
    logic bit_last;
    logic stop_last;
    logic pop_slot;

    assign ld_ready  = (fifo_count != CNTW'(FIFO_DEPTH));
    assign push      = tx_enable && ld_tx_data && ld_ready;
    assign baud_end  = (baud == 8'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_cnt == CW'(WIDTH - 1));
    assign stop_last = (bit_cnt == CW'(STOP_BITS - 1));
    // A pop is only taken when the line is free: idle, or the final stop-bit cycle.
    assign pop_slot  = (state == IDLE) || ((state == STOP) && baud_end && stop_last);
    assign pop       = tx_enable && (fifo_count != '0) && pop_slot;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tx_out      <= 1'b1;
            tx_busy     <= 1'b0;
            tx_overflow <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            baud        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            tx_overflow <= tx_enable && ld_tx_data && !ld_ready;
            if (tx_enable) begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);

                if (pop) begin
                    shift   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_bit <= ~^mem[rd_ptr];
`endif
                    state   <= START;
                    tx_out  <= 1'b0;
                    tx_busy <= 1'b1;
                    baud    <= '0;
                    bit_cnt <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            tx_out  <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                        START: begin
                            if (baud_end) begin
                                baud    <= '0;
                                bit_cnt <= '0;
                                tx_out  <= shift[0];
                                shift   <= shift >> 1;
                                state   <= DATA;
                            end else begin
                                baud <= baud + 8'd1;
                            end
                        end
                        DATA: begin
                            if (baud_end) begin
                                baud <= '0;
                                if (bit_last) begin
                                    bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                    tx_out  <= par_bit;
                                    state   <= PAR;
`else
                                    tx_out  <= 1'b1;
                                    state   <= STOP;
`endif
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    tx_out  <= shift[0];
                                    shift   <= shift >> 1;
                                end
                            end else begin
                                baud <= baud + 8'd1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PAR: begin
                            if (baud_end) begin
                                baud    <= '0;
                                bit_cnt <= '0;
                                tx_out  <= 1'b1;
                                state   <= STOP;
                            end else begin
                                baud <= baud + 8'd1;
                            end
                        end
`endif
                        STOP: begin
                            if (baud_end) begin
                                baud <= '0;
                                if (stop_last) begin
                                    bit_cnt <= '0;
                                    tx_busy <= 1'b0;
                                    state   <= IDLE;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end else begin
                                baud <= baud + 8'd1;
                            end
                        end
                        default: begin
                            state   <= IDLE;
                            tx_out  <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: framing, back-to-back queueing, overflow, enable stall, mid-frame reset, slow baud.
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL1 = 1 + 64 + P + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_enable, tx_enable2;
    logic [63:0] tx_data, tx_data2;
    logic        ld_tx_data, ld_tx_data2;
    logic        ld_ready, ld_ready2;
    logic        tx_out, tx_out2;
    logic        tx_busy, tx_busy2;
    logic [2:0]  fifo_count, fifo_count2;
    logic        tx_overflow, tx_overflow2;

    always #5 clk = ~clk;

    uart_tx_buffered #(.WIDTH(64), .FIFO_DEPTH(4), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .tx_data(tx_data),
        .ld_tx_data(ld_tx_data), .ld_ready(ld_ready), .tx_out(tx_out),
        .tx_busy(tx_busy), .fifo_count(fifo_count), .tx_overflow(tx_overflow)
    );

    uart_tx_buffered #(.WIDTH(64), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut_slow (
        .clk(clk), .reset(reset), .tx_enable(tx_enable2), .tx_data(tx_data2),
        .ld_tx_data(ld_tx_data2), .ld_ready(ld_ready2), .tx_out(tx_out2),
        .tx_busy(tx_busy2), .fifo_count(fifo_count2), .tx_overflow(tx_overflow2)
    );

    int total  = 0;
    int passed = 0;
    logic cap [0:69];

    typedef struct {
        logic [63:0] data;
        logic        par;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic exp_bit(input logic [63:0] d, input logic par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 64) return d[idx-1];
        if (P == 1 && idx == 65) return par;
        return 1'b1;
    endfunction

    task automatic push1(input logic [63:0] d);
        @(negedge clk);
        tx_data    = d;
        ld_tx_data = 1'b1;
        @(negedge clk);
        ld_tx_data = 1'b0;
    endtask

    // Samples one whole frame, starting with the start bit at the next falling edge.
    task automatic check_frame(input string name, input logic [63:0] d, input logic par,
                               input int cpb, input int nstop, input bit sel);
        int errs = 0;
        int len  = (1 + 64 + P + nstop) * cpb;
        logic b, bz;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            b  = sel ? tx_out2 : tx_out;
            bz = sel ? tx_busy2 : tx_busy;
            cap[c / cpb] = b;
            if (b !== exp_bit(d, par, c / cpb) || bz !== 1'b1) errs++;
        end
        chk(name, 64'(errs), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [0:7] seq;
        logic [7:0] got;
        logic       en_prev;
        int         k, errs;
        logic [63:0] q [6];

        vecs[0] = '{64'h0000_0000_0000_00A5, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_0001, 1'b0};
        vecs[2] = '{64'h0000_0000_0000_0003, 1'b1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0001, 1'b1};
        vecs[5] = '{64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[6] = '{64'h0000_0000_0000_0007, 1'b0};
        q[0] = 64'h1; q[1] = 64'h3; q[2] = 64'h7; q[3] = 64'hF; q[4] = 64'h1F; q[5] = 64'hDEAD;

        reset = 1'b1;
        tx_enable = 1'b1; tx_enable2 = 1'b1;
        tx_data = '0; tx_data2 = '0;
        ld_tx_data = 1'b0; ld_tx_data2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_out", tx_out, 1);
        chk("reset tx_busy", tx_busy, 0);
        chk("reset ld_ready", ld_ready, 1);
        chk("reset fifo_count", fifo_count, 0);
        chk("reset tx_overflow", tx_overflow, 0);
        chk("reset slow tx_out", tx_out2, 1);
        reset = 1'b0;

        // Single frames from the vector table.
        for (int i = 0; i < 7; i++) begin
            push1(vecs[i].data);
            chk("count after push", fifo_count, 1);
            chk("idle before start", tx_out, 1);
            check_frame($sformatf("frame %0d", i), vecs[i].data, vecs[i].par, 1, 1, 1'b0);
            if (i == 0) begin
                seq = 8'b1010_0101;
                got = '0;
                for (int j = 0; j < 8; j++) got[7-j] = cap[1+j];
                chk("A5 first byte order", got, 64'(seq));
            end
            @(negedge clk);
            chk("busy drop after frame", tx_busy, 0);
            chk("line idle after frame", tx_out, 1);
        end

        // Queue while busy: fill, overflow, then zero-gap back-to-back frames.
        push1(q[0]);
        fork
            begin
                for (int i = 0; i < 5; i++)
                    check_frame($sformatf("b2b frame %0d", i), q[i], q[i][0] ^ q[i][1] ^ q[i][2] ^ q[i][3] ^ q[i][4] ^ 1'b1, 1, 1, 1'b0);
            end
            begin
                @(negedge clk);
                chk("count with head in flight", fifo_count, 0);
                for (int i = 1; i <= 5; i++) begin
                    tx_data    = q[i];
                    ld_tx_data = 1'b1;
                    @(negedge clk);
                    if (i == 3) chk("ld_ready at 3 queued", ld_ready, 1);
                    if (i == 4) begin
                        chk("ld_ready falls at 4 queued", ld_ready, 0);
                        chk("count full", fifo_count, 4);
                    end
                    if (i == 5) chk("overflow pulse", tx_overflow, 1);
                end
                ld_tx_data = 1'b0;
                @(negedge clk);
                chk("overflow one cycle", tx_overflow, 0);
                chk("count after drop", fifo_count, 4);
            end
        join
        @(negedge clk);
        chk("b2b busy drop", tx_busy, 0);
        chk("b2b fifo empty", fifo_count, 0);
        repeat (5) @(negedge clk);
        chk("dropped packet not sent", tx_busy, 0);

        // Enable stall mid-data: 10 disabled edges stretch the frame by 10 cycles.
        push1(64'h5555_5555_5555_5555);
        en_prev = 1'b1; k = 0; errs = 0;
        for (int c = 0; c < FL1 + 10; c++) begin
            @(negedge clk);
            if (en_prev) k++;
            if (tx_out !== exp_bit(64'h5555_5555_5555_5555, 1'b1, k - 1) || tx_busy !== 1'b1) errs++;
            en_prev   = !(c >= 30 && c < 40);
            tx_enable = en_prev;
        end
        chk("stalled frame bits", 64'(errs), 0);
        @(negedge clk);
        chk("stalled frame busy drop", tx_busy, 0);

        // Reset mid-frame with two packets queued.
        push1(64'h0);
        push1(64'hFFFF_FFFF_FFFF_FFFF);
        push1(64'hFFFF_FFFF_FFFF_FFFF);
        chk("two queued", fifo_count, 2);
        repeat (28) @(negedge clk);
        chk("bit 30 before reset", tx_out, 0);
        chk("busy before reset", tx_busy, 1);
        reset = 1'b1;
        #1;
        chk("async reset tx_out", tx_out, 1);
        chk("async reset tx_busy", tx_busy, 0);
        chk("async reset fifo_count", fifo_count, 0);
        chk("async reset ld_ready", ld_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        errs = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) errs++;
        end
        chk("no frames after reset", 64'(errs), 0);

        // Slow instance: 4 clocks per bit, 2 stop bits.
        @(negedge clk);
        tx_data2    = 64'h0000_0000_0000_00A5;
        ld_tx_data2 = 1'b1;
        @(negedge clk);
        ld_tx_data2 = 1'b0;
        chk("slow idle before start", tx_out2, 1);
        check_frame("slow frame", 64'h0000_0000_0000_00A5, 1'b1, 4, 2, 1'b1);
        @(negedge clk);
        chk("slow busy drop", tx_busy2, 0);
        chk("slow overflow clear", tx_overflow2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
